dataint_ecc_hamming_decode_secded_pipe: RTL

Pipelined, parametrised SECDED Hamming decoder with valid/ready streaming on both sides. It checks and corrects codewords from the matching SECDED encoder and reports per-word status (clean/corrected/uncorrectable). It keeps saturating event counters and a first-uncorrectable-error log for CSR readout. It sits on memory or link read paths in the data-integrity library.

---
 rtl/dataint_ecc_pkg.sv | 40 ++++
 rtl/dataint_ecc_secded_syndrome.sv | 22 ++
 rtl/dataint_ecc_hamming_decode_secded_pipe.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dataint_ecc_pkg.sv
// Shared SECDED helpers: code geometry, Hamming position coverage and decode status.
package dataint_ecc_pkg;

  typedef enum logic [1:0] {ECC_CLEAN, ECC_CORR, ECC_UNCORR} ecc_status_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int secded_parity_bits(input int width);
    int p;
    p = 1;
    while ((1 << p) < width + p + 1) p++;
    return p;
  endfunction

  function automatic int secded_cw(input int width);
    return width + secded_parity_bits(width) + 1;
  endfunction

  // Codeword bit index (0-based) holding data bit k: k-th non-power-of-two position.
  function automatic int data_bit_index(input int k);
    int seen;
    int idx;
    seen = 0;
    idx  = 0;
    for (int pos = 1; seen <= k; pos++) begin
      if (!is_pow2(pos)) begin
        idx = pos - 1;
        seen++;
      end
    end
    return idx;
  endfunction

  function automatic logic hamming_covers(input int pos, input int j);
    return ((pos >> j) & 1) != 0;
  endfunction

endpackage

// File: rtl/dataint_ecc_secded_syndrome.sv
// Combinational SECDED syndrome: {overall parity mismatch, Hamming syndrome}.
module dataint_ecc_secded_syndrome
  import dataint_ecc_pkg::*;
#(
  parameter int CW = 13,
  parameter int PB = 4
) (
  input  logic [CW-1:0] codeword,
  output logic [PB:0]   syndrome
);

  for (genvar j = 0; j < PB; j++) begin : g_s
    logic [CW-2:0] mask;
    for (genvar b = 0; b < CW-1; b++) begin : g_m
      assign mask[b] = hamming_covers(b + 1, j);
    end
    assign syndrome[j] = ^(codeword[CW-2:0] & mask);
  end

  assign syndrome[PB] = ^codeword;

endmodule

// File: rtl/dataint_ecc_hamming_decode_secded_pipe.sv
// Pipelined SECDED decoder with valid/ready flow control, event counters and first-error log.
module dataint_ecc_hamming_decode_secded_pipe
  import dataint_ecc_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int PIPE_STAGES = 2,
  parameter  int CNT_WIDTH   = 16,
  localparam int ParityBits  = secded_parity_bits(WIDTH),
  localparam int CW          = secded_cw(WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CW-1:0]         i_codeword,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_err_corrected,
  output logic                  o_err_uncorrectable,
  output logic [ParityBits:0]   o_syndrome,
  input  logic                  i_cnt_clear,
  output logic [CNT_WIDTH-1:0]  o_cnt_corrected,
  output logic [CNT_WIDTH-1:0]  o_cnt_uncorrectable,
  output logic                  o_log_valid,
  output logic [ParityBits:0]   o_log_syndrome
);

  logic [ParityBits:0] in_syn;
  logic [CW-1:0]       c_cw;
  logic [ParityBits:0] c_syn;
  logic                c_vld;
  logic                out_load;
  logic                out_fire;

  dataint_ecc_secded_syndrome #(.CW(CW), .PB(ParityBits)) u_syn (
    .codeword (i_codeword),
    .syndrome (in_syn)
  );

  assign out_load = ~o_valid | i_ready;
  assign out_fire = o_valid & i_ready;

  if (PIPE_STAGES == 2) begin : g_pipe2
    logic                s0_vld;
    logic [CW-1:0]       s0_cw;
    logic [ParityBits:0] s0_syn;

    assign o_ready = ~s0_vld | out_load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s0_vld <= 1'b0;
        s0_cw  <= '0;
        s0_syn <= '0;
      end else if (o_ready) begin
        s0_vld <= i_valid;
        if (i_valid) begin
          s0_cw  <= i_codeword;
          s0_syn <= in_syn;
        end
      end
    end

    assign c_cw  = s0_cw;
    assign c_syn = s0_syn;
    assign c_vld = s0_vld;
  end else begin : g_pipe1
    assign o_ready = out_load;
    assign c_cw    = i_codeword;
    assign c_syn   = in_syn;
    assign c_vld   = i_valid;
  end

  // Correction: only a syndrome naming a real position with odd overall parity flips a bit.
  logic [CW-1:0]         fixed;
  logic [ParityBits-1:0] s;
  ecc_status_e           status;
  logic [WIDTH-1:0]      c_data;

  assign s = c_syn[ParityBits-1:0];

  always_comb begin
    fixed  = c_cw;
    status = ECC_CLEAN;
    if (c_syn[ParityBits]) begin
      if (s == '0) begin
        status = ECC_CORR;
      end else if (int'(s) <= CW-1) begin
        status = ECC_CORR;
        for (int b = 0; b < CW-1; b++)
          if (s == ParityBits'(b + 1)) fixed[b] = ~fixed[b];
      end else begin
        status = ECC_UNCORR;
      end
    end else if (s != '0) begin
      status = ECC_UNCORR;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_ext
    assign c_data[k] = fixed[data_bit_index(k)];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid             <= 1'b0;
      o_data              <= '0;
      o_err_corrected     <= 1'b0;
      o_err_uncorrectable <= 1'b0;
      o_syndrome          <= '0;
    end else if (out_load) begin
      o_valid <= c_vld;
      if (c_vld) begin
        o_data              <= c_data;
        o_err_corrected     <= (status == ECC_CORR);
        o_err_uncorrectable <= (status == ECC_UNCORR);
        o_syndrome          <= c_syn;
      end
    end
  end

  // Events are counted at delivery; clear wins over a same-cycle event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_corrected     <= '0;
      o_cnt_uncorrectable <= '0;
      o_log_valid         <= 1'b0;
      o_log_syndrome      <= '0;
    end else if (i_cnt_clear) begin
      o_cnt_corrected     <= '0;
      o_cnt_uncorrectable <= '0;
      o_log_valid         <= 1'b0;
      o_log_syndrome      <= '0;
    end else if (out_fire) begin
      if (o_err_corrected && o_cnt_corrected != '1)
        o_cnt_corrected <= o_cnt_corrected + CNT_WIDTH'(1);
      if (o_err_uncorrectable && o_cnt_uncorrectable != '1)
        o_cnt_uncorrectable <= o_cnt_uncorrectable + CNT_WIDTH'(1);
      if (o_err_uncorrectable && !o_log_valid) begin
        o_log_valid    <= 1'b1;
        o_log_syndrome <= o_syndrome;
      end
    end
  end

endmodule
